sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO, the successor to the dual-clock 8×16 FIFO. Width, depth and watermark levels are set by parameters. Adds an occupancy count, almost-full/almost-empty watermarks, a synchronous flush, and sticky overflow/underflow error flags. It buffers byte or word streams between same-clock producers and consumers, e.g. UART RX/TX paths on Basys3.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per entry (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush, active-high
- we  in  1  write request
- wdata  in  DATA_WIDTH  write data
- re  in  1  read request
- rdata  out  DATA_WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- State is held in:
  - wptr and rptr, each CW bits, with the MSB as the wrap bit
  - storage array DEPTH × DATA_WIDTH
  - count register
  - rdata register
  - two sticky flags
- Acceptance is computed from the registered state at the edge:
  - rd_ok = re & ~empty
  - wr_ok = we & (~full | rd_ok)
  - A write into a full FIFO succeeds only when a read is accepted in the same cycle.
- wr_ok: mem[wptr[CW-2:0]] ← wdata; wptr ← wptr+1. The wrap is natural modulo 2·DEPTH.
- rd_ok: rdata ← mem[rptr[CW-2:0]]; rptr ← rptr+1. rdata holds its value on every other cycle.
- count update:
  - +1 on wr_ok only
  - −1 on rd_ok only
  - unchanged when both or neither are accepted
- Empty with we&re: only the write is accepted and count goes 0→1. Underflow is set.
- overflow ← 1 on we & ~wr_ok. underflow ← 1 on re & ~rd_ok. Both stay set until rst or clr.
- All flags decode combinationally from the registered count. They never depend on same-cycle we/re.
- Priority: rst > clr > normal operation.
  - rst or clr: pointers, count, overflow and underflow go to 0. Any we/re in that cycle is ignored.
  - rst additionally clears rdata to 0. clr leaves rdata unchanged.
- Storage contents are not reset. Data lost on reset/flush is not recoverable.
- Out-of-range parameters (non-power-of-two DEPTH, levels out of range) are rejected by an elaboration-time assertion.

## Timing
- Reset values: rdata=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Read latency: re accepted at edge N makes the data valid on rdata after edge N (one cycle).
- Write-to-read: a word written at edge N can be read at edge N+1; its data appears after N+1.
- Flags and count reflect every accepted operation immediately after the same edge.
- Reset or flush asserted mid-stream takes effect at the next edge. The first post-reset operation is honoured in the cycle after rst deasserts.
- Throughput: one write and one read per cycle, sustained, at any occupancy.

## Structure
- Package fifo_pkg holds:
  - function ptr_width(depth) returning $clog2(depth)+1
  - default-parameter localparams DEF_DATA_WIDTH=8, DEF_DEPTH=16
- Sub-module fifo_mem:
  - parametrised DEPTH × DATA_WIDTH array
  - synchronous write port
  - synchronous read port with read-enable that also supplies the rdata register
  - no reset on the array
- Pointer, count and flag logic stays in sync_fifo.

## Test plan
- Reset, then write 0x01..0x10 (16 words, DEPTH=16) → full=1, count=16, almost_full asserted from count=14. A 17th write (0xFF) sets overflow=1 and leaves count=16.
- Read all 16 words → rdata=0x01..0x10 in order, each one cycle after its re. Then empty=1. One extra re sets underflow=1; rdata holds 0x10.
- Hold we=re=1 for 40 cycles at count=5 → count stays 5, pointers wrap ≥2 times, no error flags, data order preserved.
- With full=1, assert we(0xAA)+re together → both accepted, count stays 16, 0xAA later read in order. With empty=1, assert we(0x55)+re → count=1, underflow=1.
- With count=9 and overflow=1, pulse clr while we=1 → count=0, empty=1, overflow=0, rdata unchanged, that write is discarded.
- Assert rst mid-burst while re=1 → next cycle rdata=0, count=0, empty=1. Write 0x77 and read it back → rdata=0x77.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer sizing helper for the sync FIFO
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // Pointer/count width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage with registered read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port doubles as the output register; holds unless a read is accepted.
    // A same-address write in the same cycle returns the old (oldest) word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count, watermarks, flush and sticky errors
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    parameter int  AF_LEVEL   = DEPTH - 2,
    parameter int  AE_LEVEL   = 2,
    localparam int CW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = CW - 1;

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: DATA_WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
    logic          rd_ok;
    logic          wr_ok;

    // Flags decode only from registered occupancy.
    assign empty        = (cnt == '0);
    assign full         = (cnt == CW'(DEPTH));
    assign almost_full  = (cnt >= CW'(AF_LEVEL));
    assign almost_empty = (cnt <= CW'(AE_LEVEL));
    assign count        = cnt;
    assign overflow     = ovf;
    assign underflow    = unf;

    // Acceptance; a full FIFO takes a write only alongside an accepted read.
    // Reset and flush swallow any request in their cycle.
    assign rd_ok = re & ~empty & ~rst & ~clr;
    assign wr_ok = we & (~full | rd_ok) & ~rst & ~clr;

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + CW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + CW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (we && !wr_ok) begin
                ovf <= 1'b1;
            end
            if (re && !rd_ok) begin
                unf <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(wptr[AW-1:0]),
        .wdata(wdata),
        .re   (rd_ok),
        .raddr(rptr[AW-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo against a queue model
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;
    localparam int AEL   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          we  = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          re  = 1'b0;
    logic [DW-1:0] rdata;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AFL),
        .AE_LEVEL  (AEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .we          (we),
        .wdata       (wdata),
        .re          (re),
        .rdata       (rdata),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, plus sticky flags and last read word.
    logic [DW-1:0] q [$];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_rdata = '0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            mon_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // One clock: drive requests, let the edge happen, then advance the model.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                         input bit c, input bit rs);
        bit rd;
        bit wr;
        we = w; wdata = d; re = r; clr = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete(); m_ovf = 0; m_unf = 0; exp_rdata = '0;
        end else if (c) begin
            q.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            rd = r && (q.size() > 0);
            wr = w && ((q.size() < DEPTH) || rd);
            if (r && !rd) m_unf = 1;
            if (w && !wr) m_ovf = 1;
            if (rd) begin
                exp_rdata = q.pop_front();
                sb.push_back(exp_rdata);
            end
            if (wr) q.push_back(d);
        end
        #1;
        we = 0; re = 0; clr = 0; rst = 0;
    endtask

    // Monitor: every cycle compare status against the model; read data via the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("almost_full", int'(almost_full), int'(q.size() >= AFL));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AEL));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
            if (sb.size() > 0) chk("rdata_read", int'(rdata), int'(sb.pop_front()));
            else               chk("rdata_hold", int'(rdata), int'(exp_rdata));
        end
    end

    initial begin
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        mon_en = 1'b1;
        chk("reset_rdata", int'(rdata), 0);
        chk("reset_empty", int'(empty), 1);

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 16; i++) begin
            cycle(1, DW'(i), 0, 0, 0);
            if (i == 13) chk("af_below", int'(almost_full), 0);
            if (i == 14) chk("af_at14", int'(almost_full), 1);
        end
        chk("full16", int'(full), 1);
        chk("count16", int'(count), 16);
        cycle(1, 8'hFF, 0, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("count_after_ovf", int'(count), 16);

        // Drain in order, then one rejected read.
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 0, 1, 0, 0);
            chk("drain_order", int'(rdata), i);
        end
        chk("empty_after_drain", int'(empty), 1);
        cycle(0, 0, 1, 0, 0);
        chk("unf_set", int'(underflow), 1);
        chk("rdata_hold_0x10", int'(rdata), 'h10);

        // Sustained simultaneous read/write at count 5, wrapping the pointers.
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, DW'($urandom), 1, 0, 0);
        chk("steady_count", int'(count), 5);
        chk("steady_ovf", int'(overflow), 0);
        chk("steady_unf", int'(underflow), 0);

        // Write+read while full, then drain; write+read while empty.
        for (int i = 0; i < 11; i++) cycle(1, DW'($urandom), 0, 0, 0);
        chk("refull", int'(full), 1);
        cycle(1, 8'hAA, 1, 0, 0);
        chk("full_wr_rd_count", int'(count), 16);
        chk("full_wr_rd_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0);
        chk("aa_last", int'(rdata), 'hAA);
        cycle(1, 8'h55, 1, 0, 0);
        chk("empty_wr_rd_count", int'(count), 1);
        chk("empty_wr_rd_unf", int'(underflow), 1);

        // Flush at count 9 with overflow set, write request discarded.
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) cycle(1, DW'('h20 + i), 0, 0, 0);
        cycle(1, 8'hEE, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 0);
        chk("pre_clr_count", int'(count), 9);
        cycle(1, 8'h99, 0, 1, 0);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_rdata_kept", int'(rdata), 'h26);

        // Reset mid-burst, then a clean write/read.
        for (int i = 0; i < 4; i++) cycle(1, DW'('h40 + i), 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 8'h50, 1, 0, 1);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        cycle(1, 8'h77, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("post_rst_read", int'(rdata), 'h77);

        // Randomised traffic with shifting write bias, occasional flush and reset.
        for (int p = 0; p < 4; p++) begin
            int wp;
            case (p)
                0: wp = 70;
                1: wp = 30;
                2: wp = 50;
                default: wp = 90;
            endcase
            for (int i = 0; i < 500; i++) begin
                bit w;
                bit r;
                bit c;
                bit rs;
                w  = ($urandom_range(0, 99) < wp);
                r  = ($urandom_range(0, 99) < (100 - wp + 10));
                c  = ($urandom_range(0, 99) == 0);
                rs = ($urandom_range(0, 299) == 0);
                cycle(w, DW'($urandom), r, c, rs);
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
